// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: word width, fetch FSM states, default reset PC
// and the {pc, instr} entry carried through the prefetch buffer.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: redirect input, instruction memory request/response
// and the instruction stream towards the CPU.
//   master : fetch unit side (drives imem_req/imem_addr and instr_*)
//   slave  : environment side (memory + CPU + redirect source)
interface instr_fetch_if;

  logic                        redirect_valid;
  logic [cpu_pkg::WORD_W-1:0]  redirect_pc;
  logic                        imem_req;
  logic [cpu_pkg::WORD_W-1:0]  imem_addr;
  logic                        imem_ack;
  logic [cpu_pkg::WORD_W-1:0]  imem_rdata;
  logic                        instr_valid;
  logic                        instr_ready;
  logic [cpu_pkg::WORD_W-1:0]  instr;
  logic [cpu_pkg::WORD_W-1:0]  instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries with flush.
// Ports: clk, rst (async active-high), push/wr_data, pop, flush,
//        rd_data (registered head), full, empty, count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  fetch_entry_t                   wr_data,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  fetch_entry_t           head_q, head_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   do_push, do_pop;

  // Next-state for storage, pointers and the registered head view
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      rd_ptr_d = wr_ptr_d;
      count_d  = '0;
    end
    // Head is looked up in the post-write array so a push into an empty
    // buffer is visible right after the pushing edge.
    head_d  = mem_d[rd_ptr_d];
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = head_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// prefetch buffer, with redirect/flush support.
// Ports: clk, reset (async active-high), bus (instr_fetch_if.master).
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] imem_addr_q, imem_addr_d;
  logic              imem_req_q, imem_req_d;
  logic [WORD_W-1:0] pc_inc;
  logic              push, pop;
  fetch_entry_t      wr_entry, rd_entry;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occ_after_push;

  assign pop            = bus.instr_valid & bus.instr_ready;
  assign pc_inc         = fetch_pc_q + WORD_W'(1);
  assign wr_entry       = '{pc: fetch_pc_q, instr: bus.imem_rdata};
  assign occ_after_push = {1'b0, fifo_count} + OCC_W'(1) - OCC_W'(pop);

  // Fetch FSM next-state and request generation
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_addr_d = imem_addr_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = bus.redirect_pc;
        end else if (!fifo_full || pop) begin
          state_d     = WAIT;
          imem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = bus.imem_ack ? IDLE : DISCARD;
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_inc;
          if (occ_after_push < OCC_W'(DEPTH)) imem_addr_d = pc_inc;
          else                                state_d     = IDLE;
        end
      end
      DISCARD: begin
        if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
        if (bus.imem_ack)       state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    imem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= '0;
      imem_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = ~fifo_empty;
  assign bus.instr       = rd_entry.instr;
  assign bus.instr_pc    = rd_entry.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns addr+16'h1000; every word
// the CPU accepts is checked against a scoreboard of expected {pc, instr}.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_rdata = bus.imem_addr + 16'h1000;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pop    = 0;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [15:0] start, input int n);
    logic [15:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 16'(i);
      sb.push_back({pc, pc + 16'h1000});
    end
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int c = 0;
    while (n_pop < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(n_pop), 32'(n));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    sb.delete();
    n_pop = 0;
    reset = 1'b0;
  endtask

  // Scoreboard check on every accepted instruction
  always @(negedge clk) begin
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("instr_pop", {bus.instr_pc, bus.instr}, sb.pop_front());
      n_pop++;
    end
  end

  initial begin
    int cyc;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_ack       = 1'b1;
    bus.instr_ready    = 1'b1;

    // Reset values (ack held high during reset must be ignored)
    tick();
    tick();
    chk("rst_req",   32'(bus.imem_req),    32'd0);
    chk("rst_addr",  32'(bus.imem_addr),   32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr),       32'd0);
    chk("rst_pc",    32'(bus.instr_pc),    32'd0);

    // Streaming: ack tied, ready tied, one instruction per cycle
    reset = 1'b0;
    expect_seq(16'h0000, 24);
    tick();
    cyc = 1;
    chk("t1_first_req",  32'(bus.imem_req),  32'd1);
    chk("t1_first_addr", 32'(bus.imem_addr), 32'h0000);
    while (n_pop < 20 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("t1_pops",   32'(n_pop), 32'd20);
    chk("t1_cycles", 32'(cyc),   32'd22);

    // Back-pressure: buffer fills to 4, requests stop, resume on pop
    bus.instr_ready = 1'b0;
    apply_reset();
    expect_seq(16'h0000, 12);
    repeat (8) tick();
    chk("t2_full_req",   32'(bus.imem_req),    32'd0);
    chk("t2_full_valid", 32'(bus.instr_valid), 32'd1);
    chk("t2_head",       {bus.instr_pc, bus.instr}, 32'h0000_1000);
    tick();
    chk("t2_hold_pc",    32'(bus.instr_pc),    32'h0000);
    bus.instr_ready = 1'b1;
    tick();
    chk("t2_resume_req",  32'(bus.imem_req),  32'd1);
    chk("t2_resume_addr", 32'(bus.imem_addr), 32'h0004);
    wait_pops(8, 30, "t2_pops");

    // Redirect on a full buffer with a simultaneous handshake
    bus.instr_ready = 1'b0;
    apply_reset();
    sb.push_back(32'h0000_1000);
    expect_seq(16'h0200, 8);
    repeat (8) tick();
    chk("t2b_full_valid", 32'(bus.instr_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0200;
    bus.instr_ready    = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t2b_flush_valid", 32'(bus.instr_valid), 32'd0);
    chk("t2b_flush_req",   32'(bus.imem_req),    32'd0);
    tick();
    chk("t2b_new_addr", 32'(bus.imem_addr), 32'h0200);
    wait_pops(5, 30, "t2b_pops");

    // Redirect during WAIT with a slow memory: returned word dropped
    bus.imem_ack = 1'b0;
    apply_reset();
    expect_seq(16'h0040, 12);
    tick();
    chk("t3_req",  32'(bus.imem_req),  32'd1);
    chk("t3_addr", 32'(bus.imem_addr), 32'h0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0040;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_discard_req",  32'(bus.imem_req),  32'd1);
    chk("t3_discard_addr", 32'(bus.imem_addr), 32'h0000);
    tick();
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("t3_idle_req",   32'(bus.imem_req),    32'd0);
    chk("t3_drop_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("t3_new_req",  32'(bus.imem_req),  32'd1);
    chk("t3_new_addr", 32'(bus.imem_addr), 32'h0040);
    bus.imem_ack = 1'b1;
    wait_pops(8, 30, "t3_pops");

    // PC wrap from FFFF to 0000
    bus.imem_ack = 1'b0;
    apply_reset();
    expect_seq(16'hFFFE, 8);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ack       = 1'b1;
    tick();
    tick();
    chk("t4_addr", 32'(bus.imem_addr), 32'hFFFE);
    wait_pops(5, 30, "t4_pops");

    // Redirect and ack on the same edge: nothing pushed
    bus.imem_ack = 1'b0;
    apply_reset();
    expect_seq(16'h0123, 8);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0123;
    bus.imem_ack       = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ack       = 1'b0;
    chk("t5_idle_req",  32'(bus.imem_req),    32'd0);
    chk("t5_no_push",   32'(bus.instr_valid), 32'd0);
    tick();
    chk("t5_req",       32'(bus.imem_req),    32'd1);
    chk("t5_addr",      32'(bus.imem_addr),   32'h0123);
    chk("t5_still_empty", 32'(bus.instr_valid), 32'd0);
    bus.imem_ack = 1'b1;
    wait_pops(3, 20, "t5_pops");

    // Asynchronous reset mid-request
    chk("t6_pre_req",   32'(bus.imem_req),    32'd1);
    chk("t6_pre_valid", 32'(bus.instr_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_req",   32'(bus.imem_req),    32'd0);
    chk("t6_async_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_async_addr",  32'(bus.imem_addr),   32'd0);
    chk("t6_async_pc",    32'(bus.instr_pc),    32'd0);
    tick();
    tick();
    sb.delete();
    n_pop = 0;
    expect_seq(16'h0000, 8);
    reset = 1'b0;
    tick();
    chk("t6_restart_req",  32'(bus.imem_req),  32'd1);
    chk("t6_restart_addr", 32'(bus.imem_addr), 32'h0000);
    wait_pops(3, 20, "t6_pops");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning first fetch address after reset.
REQ-003 SHALL have one clock and one reset: clock clk, rising edge; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 redirect_valid  input  1  flush buffer and restart fetching at redirect_pc.
REQ-007 redirect_pc  input  16  new word address for the redirect.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  16  word address of the current request.
REQ-010 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-011 imem_rdata  input  16  instruction word from memory.
REQ-012 instr_valid  output  1  instr and instr_pc hold a valid entry.
REQ-013 instr_ready  input  1  CPU accepts the head entry.
REQ-014 instr  output  16  instruction presented to the CPU.
REQ-015 instr_pc  output  16  word address of instr.

Function
REQ-016 SHALL use FSM states IDLE (no request), WAIT (imem_req=1, data kept) and DISCARD (imem_req=1, returned data dropped).
REQ-017 SHALL allow at most one outstanding memory request; imem_req and imem_addr SHALL be registered and held stable from assertion until the edge where imem_ack=1.
REQ-018 IDLE->WAIT when buffer occupancy < DEPTH and no redirect; imem_addr = fetch_pc.
REQ-019 WAIT with imem_ack: push {fetch_pc, imem_rdata}; fetch_pc += 1 mod 2^16 (16'hFFFF wraps to 16'h0000); stay WAIT with new address if post-push/pop occupancy < DEPTH, else go IDLE.
REQ-020 WAIT with redirect_valid and no imem_ack -> DISCARD; fetch_pc <= redirect_pc.
REQ-021 WAIT with redirect_valid and imem_ack on the same edge: data dropped, fetch_pc <= redirect_pc, -> IDLE.
REQ-022 DISCARD: on imem_ack drop data -> IDLE; a further redirect in DISCARD only updates fetch_pc.
REQ-023 redirect_valid in IDLE: fetch_pc <= redirect_pc, stay IDLE that cycle.
REQ-024 redirect_valid SHALL empty the buffer on that edge; instr_valid=0 the following cycle; a simultaneous instr_valid&instr_ready handshake completes (CPU took the head), remaining entries flushed.
REQ-025 Entry pop on edge where instr_valid&instr_ready; push and pop on the same edge SHALL both occur, occupancy unchanged.
REQ-026 No bypass: data acked at edge N SHALL appear on instr/instr_pc with instr_valid=1 after edge N, even with empty buffer.
REQ-027 instr/instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-028 Buffer full (occupancy=DEPTH) SHALL block new requests; request resumes the cycle after a pop frees an entry.

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, occupancy 0, fetch_pc=RESET_PC.
REQ-030 Reset mid-request SHALL abandon the outstanding request; an imem_ack during reset or in IDLE SHALL be ignored.
REQ-031 First imem_req SHALL assert after the first clock edge with reset low.

Structure
REQ-032 Shared package cpu_pkg SHALL hold WORD_W=16, the fetch state enum (IDLE, WAIT, DISCARD) and the default RESET_PC.
REQ-033 Buffer SHALL be sub-module fetch_fifo: synchronous FIFO, DEPTH x 32 bits {pc, instr}, push/pop/flush, full/empty/count, same async reset.

Verification
REQ-034 Reset release, imem_ack tied 1, imem_rdata=imem_addr+16'h1000, instr_ready=1 -> instr_pc 0000,0001,0002... with instr 1000,1001,1002..., one per cycle after fill.
REQ-035 instr_ready=0, ack tied 1 -> exactly 4 entries accepted, imem_req low; raise ready -> imem_req high next cycle, order preserved (0000..0003 first).
REQ-036 ack delayed 3 cycles, redirect_pc=16'h0040 pulsed during WAIT -> returned word dropped, next imem_addr=0040, first valid instr_pc=0040.
REQ-037 redirect_pc=16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000.
REQ-038 redirect_valid and imem_ack on same edge in WAIT -> no entry pushed, next request addr = redirect_pc.
REQ-039 reset asserted while imem_req=1 -> imem_req and instr_valid drop without a clock edge; after release fetch restarts at RESET_PC.
